// File: rtl/hub75_row_capture_if.sv
// HUB75 receive-side bundle: raw panel inputs, latched-line read port and row status.
// master drives the panel side (driver or bench), slave is the row capture block.
interface hub75_row_capture_if #(
  parameter int unsigned CW  = 7,
  parameter int unsigned ONW = 16
);
  logic           in_SCLK;
  logic [2:0]     in_RGB0;
  logic [2:0]     in_RGB1;
  logic           in_LATCH;
  logic           in_nOE;
  logic [4:0]     in_ABCDE;
  logic [CW-1:0]  in_RD_ADDR;

  logic [5:0]     out_RD_DATA;
  logic           out_ROW_VALID;
  logic [4:0]     out_ROW;
  logic [CW-1:0]  out_COUNT;
  logic           out_SHORT;
  logic           out_OVERRUN;
  logic [ONW-1:0] out_ON_CYCLES;

  modport master (
    output in_SCLK, in_RGB0, in_RGB1, in_LATCH, in_nOE, in_ABCDE, in_RD_ADDR,
    input  out_RD_DATA, out_ROW_VALID, out_ROW, out_COUNT, out_SHORT, out_OVERRUN,
           out_ON_CYCLES
  );

  modport slave (
    input  in_SCLK, in_RGB0, in_RGB1, in_LATCH, in_nOE, in_ABCDE, in_RD_ADDR,
    output out_RD_DATA, out_ROW_VALID, out_ROW, out_COUNT, out_SHORT, out_OVERRUN,
           out_ON_CYCLES
  );
endinterface

// File: rtl/hub75_row_capture.sv
// HUB75 panel-side receiver: oversamples the link, deserialises one double-row per LATCH
// into a ping-pong line buffer. Define HUB75_RX_SYNC_EN for 2-flop input synchronisers.
module hub75_row_capture #(
  parameter int unsigned COLS = 64,
  parameter int unsigned CW   = 7,
  parameter int unsigned ONW  = 16
) (
  input logic                clk,
  input logic                rst,
  hub75_row_capture_if.slave bus
);
  localparam int unsigned AW = $clog2(COLS);
  localparam int unsigned PW = 6;

  typedef struct packed {
    logic       sclk;
    logic [2:0] rgb1;
    logic [2:0] rgb0;
    logic       latch;
    logic       noe;
    logic [4:0] abcde;
  } sample_t;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCHED} state_t;

  // nOE resets inactive so the on-time counter does not tick before real samples arrive
  localparam sample_t SMP_IDLE = '{sclk: 1'b0, rgb1: 3'd0, rgb0: 3'd0, latch: 1'b0,
                                   noe: 1'b1, abcde: 5'd0};

  sample_t raw;
  sample_t smp_q;
  logic    prev_sclk_q, prev_latch_q;

  assign raw = {bus.in_SCLK, bus.in_RGB1, bus.in_RGB0, bus.in_LATCH, bus.in_nOE, bus.in_ABCDE};

`ifdef HUB75_RX_SYNC_EN
  sample_t meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= SMP_IDLE;
      sync_q <= SMP_IDLE;
      smp_q  <= SMP_IDLE;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      smp_q  <= sync_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) smp_q <= SMP_IDLE;
    else     smp_q <= raw;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sclk_q  <= 1'b0;
      prev_latch_q <= 1'b0;
    end else begin
      prev_sclk_q  <= smp_q.sclk;
      prev_latch_q <= smp_q.latch;
    end
  end

  logic sclk_rise, latch_rise;
  assign sclk_rise  = smp_q.sclk  & ~prev_sclk_q;
  assign latch_rise = smp_q.latch & ~prev_latch_q;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d, count_inc;
  logic [ONW-1:0] on_q, on_d;
  logic           sel_q, sel_d;
  logic           row_valid_q, row_valid_d;
  logic [4:0]     row_q, row_d;
  logic [CW-1:0]  cnt_out_q, cnt_out_d;
  logic           short_q, short_d;
  logic           over_q, over_d;
  logic [ONW-1:0] on_out_q, on_out_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  bank_q [2][COLS];

  logic           wr_en;
  logic           wr_bank;
  logic [AW-1:0]  wr_col;
  logic [PW-1:0]  wr_data;
  logic [AW-1:0]  rd_col;

  // first shifted pixel lands in the far column; stop writing once the row is full
  assign count_inc = (count_q == CW'(COLS + 1)) ? count_q : count_q + CW'(1);
  assign wr_en     = sclk_rise && (count_q < CW'(COLS));
  assign wr_bank   = ~sel_q;
  assign wr_col    = AW'(COLS - 1) - count_q[AW-1:0];
  assign wr_data   = {smp_q.rgb1, smp_q.rgb0};
  assign rd_col    = bus.in_RD_ADDR[AW-1:0];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    on_d        = on_q;
    sel_d       = sel_q;
    row_valid_d = 1'b0;
    row_d       = row_q;
    cnt_out_d   = cnt_out_q;
    short_d     = short_q;
    over_d      = over_q;
    on_out_d    = on_out_q;

    case (state_q)
      S_IDLE:    if (sclk_rise) state_d = S_SHIFT;
      S_SHIFT:   state_d = S_SHIFT;
      S_LATCHED: state_d = sclk_rise ? S_SHIFT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (sclk_rise) count_d = count_inc;
    if (!smp_q.noe && !smp_q.latch && (on_q != '1)) on_d = on_q + ONW'(1);

    // a shift in the same sample as the latch edge belongs to the row being latched
    if (latch_rise) begin
      state_d     = S_LATCHED;
      row_valid_d = 1'b1;
      sel_d       = ~sel_q;
      row_d       = smp_q.abcde;
      cnt_out_d   = count_d;
      short_d     = count_d < CW'(COLS);
      over_d      = count_d > CW'(COLS);
      on_out_d    = on_q;
      count_d     = '0;
      on_d        = '0;
    end
  end

  // read follows the bank that is latched after this edge, including a same-edge write
  always_comb begin
    rd_d = '0;
    if (bus.in_RD_ADDR < CW'(COLS)) begin
      if (wr_en && (wr_bank == sel_d) && (wr_col == rd_col)) rd_d = wr_data;
      else                                                   rd_d = bank_q[sel_d][rd_col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      on_q        <= '0;
      sel_q       <= 1'b0;
      row_valid_q <= 1'b0;
      row_q       <= '0;
      cnt_out_q   <= '0;
      short_q     <= 1'b0;
      over_q      <= 1'b0;
      on_out_q    <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      on_q        <= on_d;
      sel_q       <= sel_d;
      row_valid_q <= row_valid_d;
      row_q       <= row_d;
      cnt_out_q   <= cnt_out_d;
      short_q     <= short_d;
      over_q      <= over_d;
      on_out_q    <= on_out_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < int'(COLS); c++) bank_q[b][c] <= '0;
      end
    end else if (wr_en) begin
      bank_q[wr_bank][wr_col] <= wr_data;
    end
  end

  assign bus.out_RD_DATA   = rd_q;
  assign bus.out_ROW_VALID = row_valid_q;
  assign bus.out_ROW       = row_q;
  assign bus.out_COUNT     = cnt_out_q;
  assign bus.out_SHORT     = short_q;
  assign bus.out_OVERRUN   = over_q;
  assign bus.out_ON_CYCLES = on_out_q;
endmodule

// File: tb/tb_hub75_row_capture.sv
// Bench for hub75_row_capture: drives a 4x-oversampled HUB75 link and checks each
// latched row against a per-row line-buffer model.
module tb_hub75_row_capture;
  localparam int unsigned COLS = 64;
  localparam int unsigned CW   = 7;
  localparam int unsigned ONW  = 16;
`ifdef HUB75_RX_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hub75_row_capture_if #(.CW(CW), .ONW(ONW)) bus ();
  hub75_row_capture #(.COLS(COLS), .CW(CW), .ONW(ONW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // row-level model: latched and shifting line images plus pixels shifted since last latch
  logic [5:0] m_lat   [COLS];
  logic [5:0] m_shift [COLS];
  logic [5:0] pix_q [$];
  int         on_model;
  int         e_count, e_on;
  logic       e_short, e_over;
  int         got_pulses, got_lat;
  logic [5:0] got_rd;

  always @(posedge clk) begin
    if (rst) on_model = 0;
    else if (!bus.in_nOE && !bus.in_LATCH && on_model < 65535) on_model = on_model + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) begin m_lat[c] = '0; m_shift[c] = '0; end
    pix_q.delete();
    on_model = 0;
  endtask

  task automatic model_latch();
    int n;
    logic [5:0] t;
    n = pix_q.size();
    for (int i = 0; i < n && i < COLS; i++) m_shift[COLS-1-i] = pix_q[i];
    for (int c = 0; c < COLS; c++) begin t = m_lat[c]; m_lat[c] = m_shift[c]; m_shift[c] = t; end
    e_count = (n > COLS + 1) ? COLS + 1 : n;
    e_short = n < COLS;
    e_over  = n > COLS;
    e_on    = on_model;
    on_model = 0;
    pix_q.delete();
  endtask

  task automatic shift_px(input logic [5:0] px, input bit rnd_oe);
    @(negedge clk);
    bus.in_SCLK = 1'b0;
    {bus.in_RGB1, bus.in_RGB0} = px;
    if (rnd_oe) bus.in_nOE = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (rnd_oe) bus.in_nOE = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.in_SCLK = 1'b1;
    @(negedge clk);
    pix_q.push_back(px);
  endtask

  task automatic do_latch(input logic [4:0] row, input bit same, input logic [5:0] px);
    @(negedge clk);
    bus.in_SCLK = 1'b0;
    if (same) {bus.in_RGB1, bus.in_RGB0} = px;
    @(negedge clk);
    @(negedge clk);
    bus.in_LATCH = 1'b1;
    bus.in_ABCDE = row;
    if (same) begin bus.in_SCLK = 1'b1; pix_q.push_back(px); end
    model_latch();
    got_pulses = 0;
    got_lat    = -1;
    got_rd     = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_ROW_VALID === 1'b1) begin
        got_pulses++;
        if (got_lat < 0) begin got_lat = i; got_rd = bus.out_RD_DATA; end
      end
    end
    @(negedge clk);
    bus.in_LATCH = 1'b0;
    bus.in_SCLK  = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_col(input int a, output logic [5:0] d);
    @(negedge clk);
    bus.in_RD_ADDR = CW'(a);
    @(posedge clk); #1;
    d = bus.out_RD_DATA;
  endtask

  task automatic test_reset();
    bus.in_RD_ADDR = '0;
    @(negedge clk);
    tests++; if (bus.out_ROW_VALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", bus.out_ROW_VALID); end
    tests++; if (bus.out_ROW !== 5'd0) begin fails++; $display("FAIL rst_row: got %0d expected 0", bus.out_ROW); end
    tests++; if (bus.out_COUNT !== 7'd0) begin fails++; $display("FAIL rst_count: got %0d expected 0", bus.out_COUNT); end
    tests++; if (bus.out_SHORT !== 1'b0) begin fails++; $display("FAIL rst_short: got %b expected 0", bus.out_SHORT); end
    tests++; if (bus.out_OVERRUN !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b expected 0", bus.out_OVERRUN); end
    tests++; if (bus.out_ON_CYCLES !== 16'd0) begin fails++; $display("FAIL rst_on: got %0d expected 0", bus.out_ON_CYCLES); end
    tests++; if (bus.out_RD_DATA !== 6'd0) begin fails++; $display("FAIL rst_rd: got %0d expected 0", bus.out_RD_DATA); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.out_ROW_VALID !== 1'b0) begin fails++; $display("FAIL rst_idle_valid: got %b expected 0", bus.out_ROW_VALID); end
  endtask

  task automatic test_full_row();
    logic [5:0] d;
    for (int n = 0; n < 64; n++) shift_px(6'(n), 1'b0);
    do_latch(5'd5, 1'b0, 6'd0);
    tests++; if (got_pulses != 1) begin fails++; $display("FAIL full_pulses: got %0d expected 1", got_pulses); end
    tests++; if (got_lat != EXP_LAT) begin fails++; $display("FAIL full_latency: got %0d expected %0d", got_lat, EXP_LAT); end
    tests++; if (bus.out_ROW !== 5'd5) begin fails++; $display("FAIL full_row: got %0d expected 5", bus.out_ROW); end
    tests++; if (bus.out_COUNT !== 7'd64) begin fails++; $display("FAIL full_count: got %0d expected 64", bus.out_COUNT); end
    tests++; if (bus.out_SHORT !== 1'b0) begin fails++; $display("FAIL full_short: got %b expected 0", bus.out_SHORT); end
    tests++; if (bus.out_OVERRUN !== 1'b0) begin fails++; $display("FAIL full_overrun: got %b expected 0", bus.out_OVERRUN); end
    read_col(63, d);
    tests++; if (d !== 6'd0) begin fails++; $display("FAIL full_rd63: got %0d expected 0", d); end
    read_col(0, d);
    tests++; if (d !== 6'd63) begin fails++; $display("FAIL full_rd0: got %0d expected 63", d); end
    read_col(10, d);
    tests++; if (d !== 6'd53) begin fails++; $display("FAIL full_rd10: got %0d expected 53", d); end
  endtask

  task automatic test_short_row();
    logic [5:0] d;
    for (int n = 0; n < 40; n++) shift_px(6'($urandom_range(0, 63)), 1'b0);
    do_latch(5'd17, 1'b0, 6'd0);
    tests++; if (bus.out_COUNT !== 7'd40) begin fails++; $display("FAIL short_count: got %0d expected 40", bus.out_COUNT); end
    tests++; if (bus.out_SHORT !== 1'b1) begin fails++; $display("FAIL short_flag: got %b expected 1", bus.out_SHORT); end
    tests++; if (bus.out_OVERRUN !== 1'b0) begin fails++; $display("FAIL short_overrun: got %b expected 0", bus.out_OVERRUN); end
    tests++; if (bus.out_ROW !== 5'd17) begin fails++; $display("FAIL short_row: got %0d expected 17", bus.out_ROW); end
    for (int c = 0; c < COLS; c++) begin
      read_col(c, d);
      tests++; if (d !== m_lat[c]) begin fails++; $display("FAIL short_col%0d: got %0d expected %0d", c, d, m_lat[c]); end
    end
  endtask

  task automatic test_overrun();
    logic [5:0] d;
    logic [5:0] px64;
    px64 = '0;
    for (int n = 0; n < 70; n++) begin
      d = 6'($urandom_range(0, 63));
      if (n == 63) px64 = d;
      shift_px(d, 1'b0);
    end
    do_latch(5'd30, 1'b0, 6'd0);
    tests++; if (bus.out_COUNT !== 7'd65) begin fails++; $display("FAIL over_count: got %0d expected 65", bus.out_COUNT); end
    tests++; if (bus.out_OVERRUN !== 1'b1) begin fails++; $display("FAIL over_flag: got %b expected 1", bus.out_OVERRUN); end
    tests++; if (bus.out_SHORT !== 1'b0) begin fails++; $display("FAIL over_short: got %b expected 0", bus.out_SHORT); end
    read_col(0, d);
    tests++; if (d !== px64) begin fails++; $display("FAIL over_col0: got %0d expected %0d", d, px64); end
    read_col(64, d);
    tests++; if (d !== 6'd0) begin fails++; $display("FAIL over_rd64: got %0d expected 0", d); end
  endtask

  task automatic test_on_time();
    bus.in_nOE = 1'b1;
    do_latch(5'd3, 1'b0, 6'd0);
    @(negedge clk);
    bus.in_nOE = 1'b0;
    repeat (300) @(negedge clk);
    bus.in_nOE = 1'b1;
    do_latch(5'd7, 1'b0, 6'd0);
    tests++; if (bus.out_ON_CYCLES !== 16'd300) begin fails++; $display("FAIL on_cycles: got %0d expected 300", bus.out_ON_CYCLES); end
    tests++; if (bus.out_COUNT !== 7'd0) begin fails++; $display("FAIL on_idle_count: got %0d expected 0", bus.out_COUNT); end
    tests++; if (bus.out_SHORT !== 1'b1) begin fails++; $display("FAIL on_idle_short: got %b expected 1", bus.out_SHORT); end
    tests++; if (got_pulses != 1) begin fails++; $display("FAIL on_idle_pulses: got %0d expected 1", got_pulses); end
  endtask

  task automatic test_same_edge();
    logic [5:0] d;
    logic [5:0] last;
    for (int n = 0; n < 63; n++) shift_px(6'($urandom_range(0, 63)), 1'b0);
    last = 6'($urandom_range(0, 63));
    @(negedge clk);
    bus.in_RD_ADDR = '0;
    do_latch(5'd21, 1'b1, last);
    tests++; if (bus.out_COUNT !== 7'd64) begin fails++; $display("FAIL same_count: got %0d expected 64", bus.out_COUNT); end
    tests++; if (bus.out_SHORT !== 1'b0) begin fails++; $display("FAIL same_short: got %b expected 0", bus.out_SHORT); end
    tests++; if (got_rd !== last) begin fails++; $display("FAIL same_swap_read: got %0d expected %0d", got_rd, last); end
    read_col(0, d);
    tests++; if (d !== last) begin fails++; $display("FAIL same_col0: got %0d expected %0d", d, last); end
  endtask

  task automatic test_random();
    int n;
    logic [4:0] r;
    logic [5:0] d, e;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 70);
      r = 5'($urandom_range(0, 31));
      for (int i = 0; i < n; i++) shift_px(6'($urandom_range(0, 63)), 1'b1);
      do_latch(r, 1'b0, 6'd0);
      tests++; if (got_pulses != 1) begin fails++; $display("FAIL rnd%0d_pulses: got %0d expected 1", k, got_pulses); end
      tests++; if (bus.out_ROW !== r) begin fails++; $display("FAIL rnd%0d_row: got %0d expected %0d", k, bus.out_ROW, r); end
      tests++; if (bus.out_COUNT !== CW'(e_count)) begin fails++; $display("FAIL rnd%0d_count: got %0d expected %0d", k, bus.out_COUNT, e_count); end
      tests++; if (bus.out_SHORT !== e_short) begin fails++; $display("FAIL rnd%0d_short: got %b expected %b", k, bus.out_SHORT, e_short); end
      tests++; if (bus.out_OVERRUN !== e_over) begin fails++; $display("FAIL rnd%0d_overrun: got %b expected %b", k, bus.out_OVERRUN, e_over); end
      tests++; if (bus.out_ON_CYCLES !== ONW'(e_on)) begin fails++; $display("FAIL rnd%0d_on: got %0d expected %0d", k, bus.out_ON_CYCLES, e_on); end
      for (int c = 0; c < COLS + 4; c++) begin
        read_col(c, d);
        if (c < COLS) e = m_lat[c];
        else          e = 6'd0;
        tests++; if (d !== e) begin fails++; $display("FAIL rnd%0d_col%0d: got %0d expected %0d", k, c, d, e); end
      end
    end
    bus.in_nOE = 1'b1;
  endtask

  task automatic test_reset_mid_row();
    logic [5:0] d;
    int pulses;
    for (int n = 0; n < 30; n++) shift_px(6'($urandom_range(0, 63)), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_SCLK = 1'b0;
    @(negedge clk);
    bus.in_LATCH = 1'b1;
    bus.in_ABCDE = 5'd9;
    pulses = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.out_ROW_VALID === 1'b1) pulses++; end
    @(negedge clk);
    bus.in_LATCH = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (6) begin @(posedge clk); #1; if (bus.out_ROW_VALID === 1'b1) pulses++; end
    tests++; if (pulses != 0) begin fails++; $display("FAIL mid_rst_pulses: got %0d expected 0", pulses); end
    tests++; if (bus.out_ROW !== 5'd0) begin fails++; $display("FAIL mid_rst_row: got %0d expected 0", bus.out_ROW); end
    tests++; if (bus.out_COUNT !== 7'd0) begin fails++; $display("FAIL mid_rst_count: got %0d expected 0", bus.out_COUNT); end
    tests++; if (bus.out_ON_CYCLES !== 16'd0) begin fails++; $display("FAIL mid_rst_on: got %0d expected 0", bus.out_ON_CYCLES); end
    do_latch(5'd2, 1'b0, 6'd0);
    tests++; if (got_pulses != 1) begin fails++; $display("FAIL post_rst_pulses: got %0d expected 1", got_pulses); end
    tests++; if (bus.out_COUNT !== 7'd0) begin fails++; $display("FAIL post_rst_count: got %0d expected 0", bus.out_COUNT); end
    tests++; if (bus.out_SHORT !== 1'b1) begin fails++; $display("FAIL post_rst_short: got %b expected 1", bus.out_SHORT); end
    for (int c = 0; c < COLS; c += 9) begin
      read_col(c, d);
      tests++; if (d !== m_lat[c]) begin fails++; $display("FAIL post_rst_col%0d: got %0d expected %0d", c, d, m_lat[c]); end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_SCLK    = 1'b0;
    bus.in_RGB0    = '0;
    bus.in_RGB1    = '0;
    bus.in_LATCH   = 1'b0;
    bus.in_nOE     = 1'b1;
    bus.in_ABCDE   = '0;
    bus.in_RD_ADDR = '0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_full_row();
    test_short_row();
    test_overrun();
    test_on_time();
    test_same_edge();
    test_random();
    test_reset_mid_row();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
